frame_beat_source: RTL

Stream front-end that turns an AXI-Stream video slave into the stall-qualified beat interface consumed by the Gaussian convolution pipeline. Buffers input in a 2-entry skid FIFO, locks to start-of-frame, drives `stall` and `out_frame`, checks line and frame framing, and appends flush rows after each frame. The convolution emits each row one row late, so the flush rows push the last image row out.

---
 rtl/frame_beat_source.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/frame_beat_source.sv
// frame_beat_source: AXI-Stream video slave to stall-qualified beat stream.
// A 2-entry skid FIFO decouples the slave from downstream hold, the FSM
// locks to start-of-frame, checks row/frame framing on every issued beat
// and appends zero flush rows so the one-row-late convolution can drain.
//
// Handshakes: an input beat transfers on a rising clk edge where
// s_tvalid & s_tready are both high; s_tready is derived from registered
// state only. A downstream beat transfers on every rising edge where
// stall is low; out_frame is then a function of registers only and is
// stable for the whole cycle.
module frame_beat_source #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 512,
    parameter int DATA_WIDTH      = 8 * PIXELS_PER_BEAT,
    parameter int FLUSH_ROWS      = 1
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tuser,
    input  logic                  s_tlast,
    input  logic                  hold,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] out_frame,
    output logic                  flush_active,
    output logic                  eol_err,
    output logic                  sof_err,
    input  logic                  clear_err,
    output logic                  frame_done
);

    localparam int COLS        = IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int FRAME_BEATS = IMAGE_DIM * COLS;
    localparam int FLUSH_BEATS = FLUSH_ROWS * COLS;
    localparam int COL_W       = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W       = (IMAGE_DIM > 1) ? $clog2(IMAGE_DIM) : 1;
    // Accept counter must be able to hold the terminal value FRAME_BEATS.
    localparam int ACC_W       = $clog2(FRAME_BEATS) + 1;
    localparam int FL_W        = (FLUSH_BEATS > 1) ? $clog2(FLUSH_BEATS) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_DIM - 1);
    localparam logic [ACC_W-1:0] ACC_FULL = ACC_W'(FRAME_BEATS);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLUSH_BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic [DATA_WIDTH-1:0] fifo_data_d [2];
    logic                  fifo_user_q [2];
    logic                  fifo_user_d [2];
    logic                  fifo_last_q [2];
    logic                  fifo_last_d [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic [ACC_W-1:0]      acc_cnt_q, acc_cnt_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [FL_W-1:0]       fl_cnt_q, fl_cnt_d;
    logic                  eol_err_q, eol_err_d;
    logic                  sof_err_q, sof_err_d;
    logic                  frame_done_q, frame_done_d;

    logic [DATA_WIDTH-1:0] head_data;
    logic                  head_user;
    logic                  head_last;
    logic                  in_fire;
    logic                  push;
    logic                  pop;
    logic                  eol_set;
    logic                  sof_set;

    assign head_data = fifo_data_q[rd_ptr_q];
    assign head_user = fifo_user_q[rd_ptr_q];
    assign head_last = fifo_last_q[rd_ptr_q];

    // Ready comes from registers only; held low while reset is asserted.
    assign s_tready = ~areset &
                      ((state_q == ST_IDLE) |
                       ((state_q == ST_STREAM) & (count_q != 2'd2) & (acc_cnt_q < ACC_FULL)));

    assign stall        = hold | (state_q == ST_IDLE) | ((state_q == ST_STREAM) & (count_q == 2'd0));
    assign out_frame    = ((state_q == ST_STREAM) && (count_q != 2'd0)) ? head_data : '0;
    assign flush_active = (state_q == ST_FLUSH);
    assign eol_err      = eol_err_q;
    assign sof_err      = sof_err_q;
    assign frame_done   = frame_done_q;
    assign in_fire      = s_tvalid & s_tready;

    // Next-state: FSM, skid FIFO, issue counters and sticky framing checks.
    always_comb begin
        state_d      = state_q;
        fifo_data_d  = fifo_data_q;
        fifo_user_d  = fifo_user_q;
        fifo_last_d  = fifo_last_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        acc_cnt_d    = acc_cnt_q;
        col_d        = col_q;
        row_d        = row_q;
        fl_cnt_d     = fl_cnt_q;
        frame_done_d = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        eol_set      = 1'b0;
        sof_set      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Everything before a start-of-frame beat is dropped.
                if (in_fire && s_tuser) begin
                    push      = 1'b1;
                    acc_cnt_d = ACC_W'(1);
                    col_d     = '0;
                    row_d     = '0;
                    state_d   = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (in_fire) begin
                    push      = 1'b1;
                    acc_cnt_d = acc_cnt_q + ACC_W'(1);
                end
                if (!stall) begin
                    pop     = 1'b1;
                    eol_set = (head_last != (col_q == COL_LAST));
                    sof_set = (head_user != ((col_q == '0) && (row_q == '0)));
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d = '0;
                            if (FLUSH_BEATS == 0) begin
                                state_d      = ST_IDLE;
                                frame_done_d = 1'b1;
                            end else begin
                                state_d = ST_FLUSH;
                            end
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (!hold) begin
                    if (fl_cnt_q == FL_LAST) begin
                        fl_cnt_d     = '0;
                        state_d      = ST_IDLE;
                        frame_done_d = 1'b1;
                    end else begin
                        fl_cnt_d = fl_cnt_q + FL_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (push) begin
            fifo_data_d[wr_ptr_q] = s_tdata;
            fifo_user_d[wr_ptr_q] = s_tuser;
            fifo_last_d[wr_ptr_q] = s_tlast;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // A new error in the same cycle wins over clear_err.
        eol_err_d = eol_set | (eol_err_q & ~clear_err);
        sof_err_d = sof_set | (sof_err_q & ~clear_err);
    end

    // State registers; reset discards FIFO contents and all counters.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_user_q[i] <= 1'b0;
                fifo_last_q[i] <= 1'b0;
            end
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            acc_cnt_q    <= '0;
            col_q        <= '0;
            row_q        <= '0;
            fl_cnt_q     <= '0;
            eol_err_q    <= 1'b0;
            sof_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fifo_data_q  <= fifo_data_d;
            fifo_user_q  <= fifo_user_d;
            fifo_last_q  <= fifo_last_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            acc_cnt_q    <= acc_cnt_d;
            col_q        <= col_d;
            row_q        <= row_d;
            fl_cnt_q     <= fl_cnt_d;
            eol_err_q    <= eol_err_d;
            sof_err_q    <= sof_err_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule
